// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and MEM-stage load/store; data access wins.
// Latency: m_req one cycle after the request, done/valid pulse one cycle after m_ack (2-cycle minimum).
// Backpressure: stall_m/stall_f hold the pipeline until the granted transaction completes; no preemption.
module mem_port_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        stall_m,
  output logic        stall_f,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wait_cnt;
  logic          drop;
  logic          data_req;
  logic          fetch_req;

  // A completed data access is masked during its done cycle so it is not re-issued
  assign data_req  = (mem_re | mem_we) & ~mem_done;
  assign fetch_req = if_req & ~if_flush & ~if_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: data is older than the fetch, so it wins; each access waits for its ack
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (data_req)       state_nxt = DATA;
        else if (fetch_req) state_nxt = INSTR;
      end
      DATA:    if (m_ack) state_nxt = IDLE;
      INSTR:   if (m_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stalls: a pending data access freezes everything including E/M; a fetch only freezes F/D
  always_comb begin
    stall_m = data_req;
    stall_f = if_req & ~if_valid & ~data_req;
  end

  // Memory request, completion pulses and returned data
  always_ff @(posedge clk) begin
    if (rst) begin
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
    end else begin
      mem_done <= 1'b0;
      if_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req) begin
            m_req   <= 1'b1;
            m_addr  <= mem_addr;
            m_we    <= mem_we;
            m_wdata <= mem_wdata;
          end else if (fetch_req) begin
            m_req   <= 1'b1;
            m_addr  <= if_addr;
            m_we    <= 1'b0;
            m_wdata <= '0;
          end
        end
        DATA: begin
          if (m_ack) begin
            m_req     <= 1'b0;
            mem_rdata <= m_rdata;
            mem_done  <= 1'b1;
          end
        end
        INSTR: begin
          if (m_ack) begin
            m_req <= 1'b0;
            // A flush in the ack cycle discards the word just like an earlier one
            if (!(drop || if_flush)) begin
              if_rdata <= m_rdata;
              if_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Remember a flush that hit an in-flight fetch until its ack arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (state == INSTR) begin
      if (m_ack)         drop <= 1'b0;
      else if (if_flush) drop <= 1'b1;
    end
  end

  // Watchdog: count unanswered wait cycles; the flag is sticky and the access is not aborted
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else if (state == IDLE) begin
      if (state_nxt != IDLE) wait_cnt <= '0;
    end else if (!m_ack && wait_cnt != TMAX) begin
      wait_cnt <= wait_cnt + CW'(1);
      if (wait_cnt == TMAX - CW'(1)) err <= 1'b1;
    end
  end

endmodule
